// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, stall encodings and bus layouts for the MEM stage
package mem_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int LOAD_W       = 5;
  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
  } load_bus_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - little-endian byte/half select with sign/zero extension
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_a,
  input  load_bus_t   i_load,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_rdata[{i_a, 3'b000} +: 8];
    w_half      = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_data = i_rdata;
    if (i_load.lb)       o_load_data = {{24{w_byte[7]}}, w_byte};
    else if (i_load.lbu) o_load_data = {24'd0, w_byte};
    else if (i_load.lh)  o_load_data = {{16{w_half[15]}}, w_half};
    else if (i_load.lhu) o_load_data = {16'd0, w_half};
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX->MEM register, load extraction, WB/forwarding buses
// Optional MEM_ADDR_EXC_EN adds mem_adel for misaligned LH/LHU/LW.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_STALL_BIT = 3,
  parameter int WB_STALL_BIT  = 4
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_W-1:0]       ex_load_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    mem_is_load
`ifdef MEM_ADDR_EXC_EN
  ,
  output logic                    mem_adel
`endif
);

  ex_to_mem_t  r_ex;
  load_bus_t   r_ld;
  logic [31:0] r_rdata_buf;
  logic        r_buf_valid;

  logic        w_mem_stop;
  logic        w_wb_stop;
  logic        w_bubble;
  logic        w_hold;
  logic [1:0]  w_a;
  logic [31:0] w_eff_rdata;
  logic [31:0] w_load_data;
  logic [31:0] w_result;
  logic        w_adel;
  logic        w_rf_we;
  logic        w_unused_store_ctl;

  assign w_mem_stop = (stall[MEM_STALL_BIT] == STOP);
  assign w_wb_stop  = (stall[WB_STALL_BIT] == STOP);
  assign w_bubble   = w_mem_stop && (w_wb_stop == NO_STOP);
  assign w_hold     = w_mem_stop && w_wb_stop;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex <= '0;
      r_ld <= '0;
    end else if (!w_mem_stop) begin
      r_ex <= ex_to_mem_bus;
      r_ld <= ex_load_bus;
    end
  end

  // SRAM data is only valid one cycle after the request; latch it on the first held cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_buf <= '0;
      r_buf_valid <= 1'b0;
    end else if (!w_hold) begin
      r_buf_valid <= 1'b0;
    end else if (!r_buf_valid) begin
      r_rdata_buf <= data_sram_rdata;
      r_buf_valid <= 1'b1;
    end
  end

  assign w_a         = r_ex.ex_result[1:0];
  assign w_eff_rdata = r_buf_valid ? r_rdata_buf : data_sram_rdata;

  mem_stage_load_ext u_load_ext (
    .i_rdata     (w_eff_rdata),
    .i_a         (w_a),
    .i_load      (r_ld),
    .o_load_data (w_load_data)
  );

`ifdef MEM_ADDR_EXC_EN
  assign w_adel   = ((r_ld.lh | r_ld.lhu) & w_a[0]) | (r_ld.lw & (|w_a));
  assign mem_adel = w_adel;
`else
  assign w_adel   = 1'b0;
`endif

  assign w_rf_we            = r_ex.rf_we & ~w_adel;
  assign w_result           = r_ex.sel_rf_res ? w_load_data : r_ex.ex_result;
  assign w_unused_store_ctl = &{1'b0, r_ex.ram_en, r_ex.ram_wen};

  assign mem_to_wb_bus = {r_ex.pc, w_rf_we, r_ex.rf_waddr, w_result};
  assign mem_to_rf_bus = {w_rf_we, r_ex.rf_waddr, w_result};
  assign mem_is_load   = |r_ld;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; sits between EX and WB.
- Registers the EX→MEM bus and the load-type bus under stall/bubble control.
- Picks the result source (ALU result or load data) and extracts and extends load data for LB/LBU/LH/LHU/LW from the synchronous data SRAM read port.
- Produces the MEM→WB bus and the MEM→RF forwarding bus; holds SRAM read data steady across multi-cycle stalls.

Parameters:
- MEM_STALL_BIT, 3, index of the stall bit that freezes this stage's input register.
- WB_STALL_BIT, 4, index of the stall bit for the downstream WB register.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- stall  input  `StallBus  pipeline stall vector from the stall controller.
- ex_to_mem_bus  input  `EX_TO_MEM_WD (76)  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- ex_load_bus  input  `LoadBus (5)  {lb, lbu, lh, lhu, lw}.
- data_sram_rdata  input  32  SRAM read data; valid the cycle after the EX request.
- mem_to_wb_bus  output  `MEM_TO_WB_WD (70)  {pc[69:38], rf_we[37], rf_waddr[36:32], mem_result[31:0]}.
- mem_to_rf_bus  output  `MEM_TO_RF_WD (38)  {rf_we, rf_waddr, mem_result}, used for ID forwarding.
- mem_is_load  output  1  any load bit is set in the registered load bus; drives the load-use stall request.

Behaviour:
- Input register update on posedge clk, in priority order:
  - rst: both registers ← 0.
  - stall[MEM]=Stop and stall[WB]=NoStop: both ← 0 (bubble).
  - stall[MEM]=NoStop: capture the inputs.
  - Otherwise: hold.
- All outputs are combinational from registers, so every output is 0 after reset. Latency from EX to WB bus: 1 cycle.
- Read-data hold buffer (rdata_buf[31:0], buf_valid):
  - rst, capture, or bubble: buf_valid ← 0.
  - Hold cycle with buf_valid=0: rdata_buf ← data_sram_rdata, buf_valid ← 1.
  - Hold cycle with buf_valid=1: buffer unchanged.
  - eff_rdata = buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction, with a = ex_result[1:0]:
  - Byte = eff_rdata[8a+7:8a]. LB sign-extends it; LBU zero-extends it.
  - Half = a[1] ? eff_rdata[31:16] : eff_rdata[15:0]. LH sign-extends it; LHU zero-extends it.
  - LW = eff_rdata.
  - Little-endian.
- mem_result = sel_rf_res ? load_data : ex_result.
- Load bits are mutually exclusive. If none is set while sel_rf_res=1, load_data = eff_rdata.
- Stores (ram_wen≠0) pass ex_result through with rf_we as received (0 from decode).
- Reset mid-stall clears the buffer and registers in the same cycle. No partial state survives.

Optional Feature:
- Macro: MEM_ADDR_EXC_EN.
- Defined:
  - Adds output mem_adel (1 bit).
  - mem_adel=1 when (lh|lhu) and a[0]=1, or lw and a≠0.
  - When mem_adel=1, rf_we is forced to 0 on both output buses.
  - mem_adel is 0 on reset and on bubbles.
- Undefined:
  - Port absent; low address bits are ignored for LW; LH/LHU use a[1] only.

Decomposition:
- lib/defines.vh additions: `MEM_TO_WB_WD, `MEM_TO_RF_WD.
- Reused from lib/defines.vh: `Stop/`NoStop, `StallBus, `LoadBus.
- One natural sub-module, load_ext: combinational byte/half select plus sign/zero extension. Inputs: rdata, a, load bits. Output: load_data.

Test Plan:
- LB at addr 0x...1, rdata 0x1234_80FF → WB result 0xFFFF_FF80. Same with LBU → 0x0000_0080.
- LH at a=2, rdata 0x8001_0000 → 0xFFFF_8001. LHU → 0x0000_8001. LW → 0x8001_0000.
- ALU op: sel_rf_res=0, ex_result 0xDEAD_BEEF, rf_waddr 5 → mem_to_rf_bus = {1, 5, 0xDEAD_BEEF} one cycle after EX.
- LW, then stall[3]=stall[4]=Stop for 3 cycles with data_sram_rdata changing to 0xBAD0_BAD0 after cycle 1 → result stays at the first-cycle value 0xCAFE_0001 throughout.
- stall[3]=Stop, stall[4]=NoStop → next cycle both buses are all-zero. rst asserted mid-stall → all outputs 0 the next cycle.
- MEM_ADDR_EXC_EN defined: LW at addr 0x...2 → mem_adel=1, rf_we=0. LH at a=2 → mem_adel=0.
